// File: rtl/ram_arbiter.sv
// Three-port arbiter for the shared single-port program/data RAM.
// Port 0 (CPU) has priority with a starvation cap; ports 1/2 round-robin.
module ram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int RAM_LAT = 1,
    parameter int CPU_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] adrs,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   ramAdrs,
    output logic [DW-1:0]   ramData,
    output logic            ramWe,
    input  logic [DW-1:0]   ramQ
);

    localparam int LW = $clog2(RAM_LAT + 1);
    localparam int CW = $clog2(CPU_MAX + 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(RAM_LAT);
    localparam logic [CW-1:0] RUN_MAX  = CW'(CPU_MAX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] adrs_q, adrs_d;
    logic [DW-1:0] data_q, data_d;
    logic          ramWe_q, ramWe_d;
    logic          weLatch_q, weLatch_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [CW-1:0] run_q, run_d;
    // rr_q = 0 prefers port 1, rr_q = 1 prefers port 2
    logic          rr_q, rr_d;

    logic          dma_w;
    logic          p0_win;
    logic [2:0]    pick;
    logic          sel_we;
    logic [AW-1:0] sel_adrs;
    logic [DW-1:0] sel_data;

    always_comb begin
        dma_w  = req[1] | req[2];
        p0_win = req[0] && !(dma_w && (run_q == RUN_MAX));
        pick   = 3'b000;
        if (p0_win) begin
            pick = 3'b001;
        end else if (!rr_q) begin
            if (req[1])      pick = 3'b010;
            else if (req[2]) pick = 3'b100;
        end else begin
            if (req[2])      pick = 3'b100;
            else if (req[1]) pick = 3'b010;
        end
    end

    always_comb begin
        sel_we   = we[0];
        sel_adrs = adrs[AW-1:0];
        sel_data = wdata[DW-1:0];
        if (pick[1]) begin
            sel_we   = we[1];
            sel_adrs = adrs[2*AW-1:AW];
            sel_data = wdata[2*DW-1:DW];
        end else if (pick[2]) begin
            sel_we   = we[2];
            sel_adrs = adrs[3*AW-1:2*AW];
            sel_data = wdata[3*DW-1:2*DW];
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = 3'b000;
        rdata_d   = rdata_q;
        adrs_d    = adrs_q;
        data_d    = data_q;
        ramWe_d   = 1'b0;
        weLatch_d = weLatch_q;
        lat_d     = lat_q;
        run_d     = run_q;
        rr_d      = rr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d     = pick;
                    adrs_d    = sel_adrs;
                    data_d    = sel_data;
                    weLatch_d = sel_we;
                    ramWe_d   = sel_we;
                    state_d   = ISSUE;
                    if (pick[0]) begin
                        if (!dma_w)
                            run_d = '0;
                        else if (run_q != RUN_MAX)
                            run_d = run_q + 1'b1;
                    end else begin
                        run_d = '0;
                        rr_d  = pick[1];
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == LW'(1)) begin
                    if (!weLatch_q)
                        rdata_d = ramQ;
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ACK: begin
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            ack_q     <= 3'b000;
            rdata_q   <= '0;
            adrs_q    <= '0;
            data_q    <= '0;
            ramWe_q   <= 1'b0;
            weLatch_q <= 1'b0;
            lat_q     <= '0;
            run_q     <= '0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            adrs_q    <= adrs_d;
            data_q    <= data_d;
            ramWe_q   <= ramWe_d;
            weLatch_q <= weLatch_d;
            lat_q     <= lat_d;
            run_q     <= run_d;
            rr_q      <= rr_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign ramAdrs = adrs_q;
    assign ramData = data_q;
    assign ramWe   = ramWe_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: requester agents, a behavioural RAM and a
// transaction-level model of the grant/latency rules.
module tb_ram_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int RAM_LAT = 1;
    localparam int CPU_MAX = 4;
    localparam int OW      = 7 + AW + DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      req, we, gnt, ack;
    logic [3*AW-1:0] adrs;
    logic [3*DW-1:0] wdata;
    logic [DW-1:0]   rdata, ramData, ramQ;
    logic [AW-1:0]   ramAdrs;
    logic            ramWe;

    ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(RAM_LAT), .CPU_MAX(CPU_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adrs(adrs),
        .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
        .ramAdrs(ramAdrs), .ramData(ramData), .ramWe(ramWe), .ramQ(ramQ)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 16'h0042) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    logic [DW-1:0] ram [int];
    always @(posedge clk) begin
        if (ramWe) ram[int'(ramAdrs)] = ramData;
        ramQ <= ram.exists(int'(ramAdrs)) ? ram[int'(ramAdrs)] : init_val(ramAdrs);
    end

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    txn_t pq [3][$];
    int   obs [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [2:0] gnt_prev = 3'b000;

    // model state
    logic [DW-1:0] mem_m [int];
    bit            m_busy;
    int            m_age, m_win, m_run, m_rr;
    logic          m_wr;
    logic [AW-1:0] m_adrs;
    logic [DW-1:0] m_wd, m_rdata;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        return mem_m.exists(int'(a)) ? mem_m[int'(a)] : init_val(a);
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic [2:0] g, k;
        logic       w;
        g = m_busy ? 3'(1 << m_win) : 3'b000;
        k = (m_busy && m_age == RAM_LAT + 1) ? g : 3'b000;
        w = m_busy && m_age == 0 && m_wr;
        return {g, k, w, m_adrs, m_rdata};
    endfunction

    task automatic model_step();
        bit dma;
        int w;
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_win = 0; m_run = 0; m_rr = 1;
            m_wr = 0; m_adrs = '0; m_wd = '0; m_rdata = '0;
            return;
        end
        if (!m_busy) begin
            if (req != 3'b000) begin
                dma = req[1] | req[2];
                if (req[0] && !(dma && m_run == CPU_MAX)) w = 0;
                else if (req[m_rr]) w = m_rr;
                else w = 3 - m_rr;
                if (w == 0) m_run = dma ? ((m_run < CPU_MAX) ? m_run + 1 : CPU_MAX) : 0;
                else begin m_run = 0; m_rr = 3 - w; end
                m_win = w; m_busy = 1; m_age = 0;
                m_adrs = adrs[w*AW +: AW];
                m_wd = wdata[w*DW +: DW];
                m_wr = we[w];
            end
        end else begin
            if (m_age == 0 && m_wr) mem_m[int'(m_adrs)] = m_wd;
            if (m_age == RAM_LAT && !m_wr) m_rdata = m_read(m_adrs);
            if (m_age == RAM_LAT + 1) m_busy = 0;
            else m_age++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (pq[i].size() > 0) begin
                req[i] = 1'b1;
                we[i] = pq[i][0].w;
                adrs[i*AW +: AW] = pq[i][0].a;
                wdata[i*DW +: DW] = pq[i][0].d;
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    // called at negedge: react to ack, drive, step model, advance one cycle
    task automatic tick();
        if (gnt != 3'b000 && gnt_prev == 3'b000)
            obs.push_back(gnt[0] ? 0 : (gnt[1] ? 1 : 2));
        gnt_prev = gnt;
        for (int i = 0; i < 3; i++)
            if (ack[i] === 1'b1 && pq[i].size() > 0) void'(pq[i].pop_front());
        drive();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        txn_t t;
        t.w = w; t.a = a; t.d = d;
        pq[p].push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) pq[i].delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            n_chk++;
            if ({gnt, ack, ramWe, ramAdrs, rdata} !== {3'b000, 3'b000, 1'b0, 16'h0, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got gnt=%b ack=%b we=%b adrs=%h rdata=%h, want all 0",
                         cyc, gnt, ack, ramWe, ramAdrs, rdata);
            end
        end
    endtask

    task automatic test_cpu_read();
        push(0, 1'b0, 16'h0042, 16'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_chk++;
            if (ramWe !== 1'b0) begin
                n_fail++;
                $display("FAIL cpu_read_we cyc %0d: ramWe=%b want 0", cyc, ramWe);
            end
            if (k == 1) begin
                n_chk++;
                if (gnt !== 3'b001) begin
                    n_fail++;
                    $display("FAIL cpu_read_gnt: gnt=%b want 001", gnt);
                end
            end
            if (k == 3) begin
                n_chk++;
                if (ack !== 3'b001 || rdata !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL cpu_read_ack: ack=%b rdata=%h want 001/1234", ack, rdata);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int wes = 0;
        push(1, 1'b1, 16'h0100, 16'hBEEF);
        push(1, 1'b0, 16'h0100, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 4 && ramWe === 1'b1) wes++;
            if (k == 3) begin
                n_chk++;
                if (ack !== 3'b010 || rdata !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL write_ack: ack=%b rdata=%h want 010/1234", ack, rdata);
                end
            end
            if (k == 7) begin
                n_chk++;
                if (ack !== 3'b010 || rdata !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL read_back: ack=%b rdata=%h want 010/beef", ack, rdata);
                end
            end
        end
        n_chk++;
        if (wes !== 1) begin
            n_fail++;
            $display("FAIL write_we_pulse: ramWe high %0d cycles want 1", wes);
        end
    endtask

    task automatic test_cpu_starve();
        int exp_ord [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        obs.delete();
        for (int i = 0; i < 8; i++) push(0, 1'b0, 16'(i), 16'h0);
        for (int i = 0; i < 2; i++) push(1, 1'b0, 16'(16'h200 + i), 16'h0);
        for (int k = 0; k < 80; k++) begin
            tick();
            n_chk++;
            if ({gnt, ack, ramWe, ramAdrs, rdata} !== model_out()) begin
                n_fail++;
                $display("FAIL starve_model cyc %0d: got %h want %h", cyc,
                         {gnt, ack, ramWe, ramAdrs, rdata}, model_out());
            end
            if (pq[0].size() == 0 && pq[1].size() == 0 && !m_busy) break;
        end
        n_chk++;
        if (obs.size() != 10) begin
            n_fail++;
            $display("FAIL starve_count: %0d grants want 10", obs.size());
        end
        for (int i = 0; i < 10 && i < obs.size(); i++) begin
            n_chk++;
            if (obs[i] != exp_ord[i]) begin
                n_fail++;
                $display("FAIL starve_order[%0d]: port %0d want %0d", i, obs[i], exp_ord[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ord [4] = '{1, 2, 1, 2};
        do_reset();
        obs.delete();
        for (int i = 0; i < 2; i++) begin
            push(1, 1'b0, 16'(16'h300 + i), 16'h0);
            push(2, 1'b0, 16'(16'h400 + i), 16'h0);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            n_chk++;
            if ({gnt, ack, ramWe, ramAdrs, rdata} !== model_out()) begin
                n_fail++;
                $display("FAIL rr_model cyc %0d: got %h want %h", cyc,
                         {gnt, ack, ramWe, ramAdrs, rdata}, model_out());
            end
            if (pq[1].size() == 0 && pq[2].size() == 0 && !m_busy) break;
        end
        n_chk++;
        if (obs.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: %0d grants want 4", obs.size());
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            n_chk++;
            if (obs[i] != exp_ord[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: port %0d want %0d", i, obs[i], exp_ord[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        push(2, 1'b0, 16'h0500, 16'h0);
        tick();
        tick();
        push(0, 1'b0, 16'h0042, 16'h0);
        rst_n = 1'b0;
        pq[2].delete();
        tick();
        rst_n = 1'b1;
        n_chk++;
        if (gnt !== 3'b000 || ack !== 3'b000 || ramWe !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: gnt=%b ack=%b we=%b want 000/000/0", gnt, ack, ramWe);
        end
        obs.delete();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_chk++;
            if (ack[2] !== 1'b0 || {gnt, ack, ramWe, ramAdrs, rdata} !== model_out()) begin
                n_fail++;
                $display("FAIL midreset_model cyc %0d: got %h want %h", cyc,
                         {gnt, ack, ramWe, ramAdrs, rdata}, model_out());
            end
        end
        n_chk++;
        if (obs.size() < 1 || obs[0] != 0) begin
            n_fail++;
            $display("FAIL midreset_first: first grant %0d want 0",
                     obs.size() > 0 ? obs[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if (k < 400 && $urandom_range(0, 3) == 0) begin
                int p = $urandom_range(0, 2);
                a = 16'(16'h0600 + $urandom_range(0, 7));
                if (pq[p].size() < 2) push(p, 1'($urandom_range(0, 1)), a, 16'($urandom));
            end
            tick();
            n_chk++;
            if ({gnt, ack, ramWe, ramAdrs, rdata} !== model_out()) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h want %h", cyc,
                         {gnt, ack, ramWe, ramAdrs, rdata}, model_out());
            end
        end
        n_chk++;
        if (pq[0].size() + pq[1].size() + pq[2].size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d requests left want 0",
                     pq[0].size() + pq[1].size() + pq[2].size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; adrs = '0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_write_read();
        test_cpu_starve();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port synchronous program/data RAM among three requesters:
- port 0: CPU memory interface (MAR/MDR traffic and instruction fetch)
- ports 1 and 2: DMA/video readers

Each requester uses a req/ack handshake. The arbiter latches the winning request, sequences one RAM access and returns read data with a one-cycle ack. Port 0 has fixed priority, bounded by a starvation limit. Ports 1 and 2 share round-robin priority.

Parameters:
AW, 16, address width
DW, 16, data width
RAM_LAT, 1, RAM read latency in cycles (>=1)
CPU_MAX, 4, max consecutive port-0 grants while port 1 or 2 is waiting (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
req  in  3  request per port, bit i = port i
we  in  3  write flag per port, sampled at grant
adrs  in  3*AW  packed addresses {p2,p1,p0}
wdata  in  3*DW  packed write data {p2,p1,p0}
gnt  out  3  one-hot, port currently owning the RAM
ack  out  3  one-cycle completion pulse per port
rdata  out  DW  read data, valid in the ack cycle
ramAdrs  out  AW  RAM address
ramData  out  DW  RAM write data
ramWe  out  1  RAM write enable
ramQ  in  DW  RAM read data

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, gnt=0, ack=0, ramWe=0, ramAdrs=0, ramData=0, rdata=0, rrPtr=port1, cpuRun=0. Reset mid-transaction aborts it: no ack issued, ramWe low after that edge.
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE, with any req bit set, picks a winner:
  - Port 0 wins if req[0]=1, unless req[1]|req[2] and cpuRun==CPU_MAX.
  - Otherwise the first requesting port among {rrPtr, other} wins.
  - On this edge: latch adrs/wdata/we of the winner into ramAdrs/ramData/weLatch, set gnt one-hot, go to ISSUE.
- IDLE with req=0: stay, outputs hold, ramWe=0.
- ISSUE (1 cycle): ramWe=weLatch for exactly this cycle; ramAdrs/ramData stable. Latency counter loads RAM_LAT. Next state WAIT.
- WAIT (RAM_LAT cycles): ramWe=0.
  - At the final WAIT edge, rdata<=ramQ if the access was a read.
  - On a write, rdata holds its previous value.
  - Next state ACK.
- ACK (1 cycle): ack[g]=1 for the granted port, rdata valid, gnt still asserted. Next edge: gnt=0, ack=0, go to IDLE.
- Fairness bookkeeping, updated at the grant edge:
  - Port 0 granted while req[1]|req[2]: cpuRun++ (saturating at CPU_MAX).
  - Port 1 or 2 granted: cpuRun=0, rrPtr=the other DMA port.
  - Port 0 granted with no DMA request pending: cpuRun=0.
- Latency, read, RAM_LAT=1: req seen in IDLE cycle N -> ISSUE N+1 -> WAIT N+2 -> ACK N+3. Throughput is one access per RAM_LAT+3 cycles.
- Requester rules:
  - Hold req/adrs/wdata/we stable until ack (the arbiter samples only at grant).
  - Drop req on the edge where ack is seen. req still high in the following IDLE cycle counts as a new request.
- Requests that arrive during ISSUE/WAIT/ACK are ignored until IDLE. Simultaneous requests are resolved only by the priority rules above.
- req dropped before ack (protocol violation): the access still completes and ack still pulses.
- gnt is always one-hot or zero. ack is never asserted outside ACK.
- No address arithmetic: addresses pass through unmodified, no wrap handling.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, req=0 -> gnt=0, ack=0, ramWe=0, ramAdrs=0, rdata=0 for 10 cycles.
2. Single CPU read: RAM holds 0x1234 at 0x0042. req[0]=1, adrs0=0x0042, we[0]=0 -> gnt=001 one cycle later, ramWe never high, ack[0] pulses at cycle N+3 with rdata=0x1234.
3. Write then read: port 1 writes 0xBEEF to 0x0100 (ramWe high for exactly 1 cycle, ack[1] at N+3, rdata unchanged), then reads 0x0100 -> rdata=0xBEEF.
4. CPU starvation limit, CPU_MAX=4: req[0] and req[1] held continuously (re-raised after each ack) -> grant order 0,0,0,0,1,0,0,0,0,1.
5. Round-robin: req[1] and req[2] held, req[0]=0 -> grant order 1,2,1,2. Sequence starts with port 1 after reset.
6. Reset mid-access: assert rst_n=0 during WAIT of a port-2 read -> no ack[2], gnt=0 and state IDLE after the edge. Pending req[0] is granted first after release.
